ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the 5-stage pipelined RISC-V core. It holds the ID/EX pipeline register and the 32-bit ALU, and drives the EX/MEM pipeline register. It latches the decoded instruction, including the 3-bit ALUControl produced by the ALU decoder. It selects operand B, computes the result and the branch zero flag, and forwards the result, store data and control bits to the memory stage. It also supports pipeline stall and flush from the hazard unit.

## Interface
Parameters:
- WIDTH, 32, datapath width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- id_valid  in  1  decode stage presents a real instruction
- id_ALUControl  in  3  000 add, 001 sub, 010 and, 011 or, 100 slt
- id_ALUSrc  in  1  1 = operand B is id_imm
- id_rd1, id_rd2  in  WIDTH  register-file read data
- id_imm  in  WIDTH  sign-extended immediate
- id_rs1, id_rs2, id_rd  in  5  register indices
- id_RegWrite, id_MemWrite  in  1  control bits carried to MEM
- id_ResultSrc  in  2  writeback select carried to MEM
- stall_e  in  1  hold ID/EX, issue bubble to EX/MEM
- flush_e  in  1  load bubble into ID/EX
- wb_RegWrite  in  1  writeback stage write enable (forwarding source)
- wb_rd  in  5  writeback destination
- wb_Result  in  WIDTH  writeback value
- ex_zero  out  1  ALU result == 0 and EX valid (combinational from ID/EX)
- mem_valid  out  1  EX/MEM holds a real instruction
- mem_ALUResult, mem_WriteData  out  WIDTH  registered result / store data
- mem_rd  out  5; mem_RegWrite, mem_MemWrite  out  1; mem_ResultSrc  out  2  registered control

## Operation
- **ID/EX register, per edge, priority reset > flush_e > stall_e > load.**
  - Load: capture all id_* fields; valid = id_valid.
  - Flush: valid = 0, RegWrite = 0, MemWrite = 0; data fields are don't-care but must be zeroed.
  - Stall: hold every field except the rd1/rd2 operand fields, which reload with the current forwarded operands A and write-data.
- **EX computation (combinational):**
  - A = fwdA(rd1). WD = fwdB(rd2). B = ALUSrc ? imm : WD.
  - ALU results:
    - 000: A+B, mod 2^WIDTH.
    - 001: A−B, mod 2^WIDTH.
    - 010: A&B.
    - 011: A|B.
    - 100: {0…,1} if $signed(A) < $signed(B), else 0.
    - 101–111: result 0.
  - ex_zero = valid & (result == 0).
- **EX/MEM register, per edge:**
  - If reset or stall_e or !ID/EX.valid: mem_valid = 0, mem_RegWrite = 0, mem_MemWrite = 0.
  - Otherwise capture result, WD, rd and control; mem_valid = 1.
  - flush_e does not affect EX/MEM in the same cycle. The instruction currently in EX still retires.

## Timing
- Reset value: every ID/EX and EX/MEM field is 0. All outputs are 0 the cycle after reset, including ex_zero.
- Latency: id_* captured at edge N → mem_* valid after edge N+1.
- Throughput: one instruction per cycle when stall_e = 0.
- stall_e held k cycles: the ID/EX instruction is issued exactly once, on the edge after stall_e falls. EX/MEM shows k bubbles.
- flush_e and stall_e both high: flush wins, and EX/MEM also takes a bubble.
- reset asserted mid-stream: both stages are cleared at that edge, and no partial instruction reaches MEM.

## Configuration
- EX_FORWARD_EN defined:
  - fwdX(v) returns mem_ALUResult if mem_valid & mem_RegWrite & mem_rd == rsX & rsX != 0.
  - Else it returns wb_Result if wb_RegWrite & wb_rd == rsX & rsX != 0.
  - Else it returns v. EX/MEM has priority over WB.
- EX_FORWARD_EN undefined: fwdX(v) = v. The wb_* ports are present but ignored. Stall reload rewrites the fields with their own values, which is equivalent to a hold.

## Test plan
- ADD, no hazards: rd1=5, imm=7, ALUSrc=1, ALUControl=000 → two edges later mem_ALUResult=12, mem_valid=1, mem_rd unchanged.
- SUB zero and wrap: A=B=0x10, 001 → ex_zero=1. Then A=0, B=1 → result 0xFFFFFFFF, ex_zero=0.
- SLT signed: A=0xFFFFFFFF, B=1, 100 → result 1. Swap operands → result 0. Code 101 → result 0.
- Back-to-back dependency (EX_FORWARD_EN): x5=3+4, then x6=x5+x5 with stale rd1=rd2=0.
  - Second result must be 14.
  - With x5 written by WB and by EX/MEM simultaneously at different values, the EX/MEM value is used.
- Stall 2 cycles, then flush: mem_valid shows 0,0 during the stall, then the held instruction is issued once. A flush with a simultaneous stall produces no issue. Reset mid-stall clears all outputs to 0.
- rd=x0 producer: writes x0=9, consumer reads x0 → forwarded operand remains 0.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, 32-bit ALU, EX/MEM register with stall/flush handling.
// Define EX_FORWARD_EN to forward EX/MEM and WB results into the ALU operands.
module ex_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [2:0]       id_ALUControl,
    input  logic             id_ALUSrc,
    input  logic [WIDTH-1:0] id_rd1,
    input  logic [WIDTH-1:0] id_rd2,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_RegWrite,
    input  logic             id_MemWrite,
    input  logic [1:0]       id_ResultSrc,
    input  logic             stall_e,
    input  logic             flush_e,
    input  logic             wb_RegWrite,
    input  logic [4:0]       wb_rd,
    input  logic [WIDTH-1:0] wb_Result,
    output logic             ex_zero,
    output logic             mem_valid,
    output logic [WIDTH-1:0] mem_ALUResult,
    output logic [WIDTH-1:0] mem_WriteData,
    output logic [4:0]       mem_rd,
    output logic             mem_RegWrite,
    output logic             mem_MemWrite,
    output logic [1:0]       mem_ResultSrc
);

    logic             e_valid;
    logic [2:0]       e_alu_control;
    logic             e_alu_src;
    logic [WIDTH-1:0] e_rd1;
    logic [WIDTH-1:0] e_rd2;
    logic [WIDTH-1:0] e_imm;
    logic [4:0]       e_rs1;
    logic [4:0]       e_rs2;
    logic [4:0]       e_rd;
    logic             e_reg_write;
    logic             e_mem_write;
    logic [1:0]       e_result_src;

    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] write_data;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] alu_result;

`ifdef EX_FORWARD_EN
    // EX/MEM is the younger producer, so it takes priority over WB.
    always_comb begin
        src_a = e_rd1;
        if (mem_valid && mem_RegWrite && (mem_rd == e_rs1) && (e_rs1 != 5'd0))
            src_a = mem_ALUResult;
        else if (wb_RegWrite && (wb_rd == e_rs1) && (e_rs1 != 5'd0))
            src_a = wb_Result;
    end

    always_comb begin
        write_data = e_rd2;
        if (mem_valid && mem_RegWrite && (mem_rd == e_rs2) && (e_rs2 != 5'd0))
            write_data = mem_ALUResult;
        else if (wb_RegWrite && (wb_rd == e_rs2) && (e_rs2 != 5'd0))
            write_data = wb_Result;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{wb_RegWrite, wb_rd, wb_Result, e_rs1, e_rs2};
    assign src_a      = e_rd1;
    assign write_data = e_rd2;
`endif

    assign src_b = e_alu_src ? e_imm : write_data;

    always_comb begin
        alu_result = '0;
        case (e_alu_control)
            3'b000:  alu_result = src_a + src_b;
            3'b001:  alu_result = src_a - src_b;
            3'b010:  alu_result = src_a & src_b;
            3'b011:  alu_result = src_a | src_b;
            3'b100:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            default: alu_result = '0;
        endcase
    end

    assign ex_zero = e_valid && (alu_result == '0);

    // Stall reloads the operands with their forwarded values so a producer
    // leaving EX/MEM or WB during the stall is not lost.
    always_ff @(posedge clk) begin
        if (reset || flush_e) begin
            e_valid       <= 1'b0;
            e_alu_control <= '0;
            e_alu_src     <= 1'b0;
            e_rd1         <= '0;
            e_rd2         <= '0;
            e_imm         <= '0;
            e_rs1         <= '0;
            e_rs2         <= '0;
            e_rd          <= '0;
            e_reg_write   <= 1'b0;
            e_mem_write   <= 1'b0;
            e_result_src  <= '0;
        end else if (stall_e) begin
            e_rd1 <= src_a;
            e_rd2 <= write_data;
        end else begin
            e_valid       <= id_valid;
            e_alu_control <= id_ALUControl;
            e_alu_src     <= id_ALUSrc;
            e_rd1         <= id_rd1;
            e_rd2         <= id_rd2;
            e_imm         <= id_imm;
            e_rs1         <= id_rs1;
            e_rs2         <= id_rs2;
            e_rd          <= id_rd;
            e_reg_write   <= id_RegWrite;
            e_mem_write   <= id_MemWrite;
            e_result_src  <= id_ResultSrc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid     <= 1'b0;
            mem_ALUResult <= '0;
            mem_WriteData <= '0;
            mem_rd        <= '0;
            mem_RegWrite  <= 1'b0;
            mem_MemWrite  <= 1'b0;
            mem_ResultSrc <= '0;
        end else if (stall_e || !e_valid) begin
            mem_valid    <= 1'b0;
            mem_RegWrite <= 1'b0;
            mem_MemWrite <= 1'b0;
        end else begin
            mem_valid     <= 1'b1;
            mem_ALUResult <= alu_result;
            mem_WriteData <= write_data;
            mem_rd        <= e_rd;
            mem_RegWrite  <= e_reg_write;
            mem_MemWrite  <= e_mem_write;
            mem_ResultSrc <= e_result_src;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, pipeline latency, forwarding, stall, flush, reset.
module tb_ex_stage;
    localparam int W = 32;

`ifdef EX_FORWARD_EN
    localparam logic [W-1:0] EXP_DEP  = 32'd14;
    localparam logic [W-1:0] EXP_WD   = 32'd7;
    localparam logic [W-1:0] EXP_PRIO = 32'd20;
    localparam logic [W-1:0] EXP_WB   = 32'd99;
`else
    localparam logic [W-1:0] EXP_DEP  = 32'd0;
    localparam logic [W-1:0] EXP_WD   = 32'd0;
    localparam logic [W-1:0] EXP_PRIO = 32'd0;
    localparam logic [W-1:0] EXP_WB   = 32'd0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         id_valid;
    logic [2:0]   id_ALUControl;
    logic         id_ALUSrc;
    logic [W-1:0] id_rd1, id_rd2, id_imm;
    logic [4:0]   id_rs1, id_rs2, id_rd;
    logic         id_RegWrite, id_MemWrite;
    logic [1:0]   id_ResultSrc;
    logic         stall_e, flush_e;
    logic         wb_RegWrite;
    logic [4:0]   wb_rd;
    logic [W-1:0] wb_Result;
    logic         ex_zero, mem_valid;
    logic [W-1:0] mem_ALUResult, mem_WriteData;
    logic [4:0]   mem_rd;
    logic         mem_RegWrite, mem_MemWrite;
    logic [1:0]   mem_ResultSrc;

    int n_checks = 0;
    int n_fail   = 0;

    ex_stage #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_ALUControl(id_ALUControl),
        .id_ALUSrc(id_ALUSrc), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_RegWrite(id_RegWrite),
        .id_MemWrite(id_MemWrite), .id_ResultSrc(id_ResultSrc), .stall_e(stall_e),
        .flush_e(flush_e), .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_Result(wb_Result),
        .ex_zero(ex_zero), .mem_valid(mem_valid), .mem_ALUResult(mem_ALUResult),
        .mem_WriteData(mem_WriteData), .mem_rd(mem_rd), .mem_RegWrite(mem_RegWrite),
        .mem_MemWrite(mem_MemWrite), .mem_ResultSrc(mem_ResultSrc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] ctl, input logic src,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] imm,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rw, input logic mw, input logic [1:0] rsrc);
        id_valid = v; id_ALUControl = ctl; id_ALUSrc = src;
        id_rd1 = a; id_rd2 = b; id_imm = imm;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_RegWrite = rw; id_MemWrite = mw; id_ResultSrc = rsrc;
    endtask

    task automatic idle();
        drive(1'b0, 3'b000, 1'b0, '0, '0, '0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic test_reset();
        reset = 1'b1; stall_e = 1'b0; flush_e = 1'b0;
        wb_RegWrite = 1'b0; wb_rd = 5'd0; wb_Result = '0;
        drive(1'b1, 3'b000, 1'b1, 32'd5, 32'd6, 32'd7, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 2'b10);
        tick(); tick();
        n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_valid: actual %b required 0", mem_valid); end
        n_checks++; if (mem_ALUResult !== 32'd0) begin n_fail++; $display("FAIL reset_result: actual %h required 0", mem_ALUResult); end
        n_checks++; if (mem_WriteData !== 32'd0) begin n_fail++; $display("FAIL reset_wd: actual %h required 0", mem_WriteData); end
        n_checks++; if (mem_rd !== 5'd0) begin n_fail++; $display("FAIL reset_rd: actual %0d required 0", mem_rd); end
        n_checks++; if (mem_RegWrite !== 1'b0 || mem_MemWrite !== 1'b0) begin n_fail++; $display("FAIL reset_we: actual %b%b required 00", mem_RegWrite, mem_MemWrite); end
        n_checks++; if (mem_ResultSrc !== 2'b00) begin n_fail++; $display("FAIL reset_rsrc: actual %b required 00", mem_ResultSrc); end
        n_checks++; if (ex_zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero: actual %b required 0", ex_zero); end
        reset = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_add();
        drive(1'b1, 3'b000, 1'b1, 32'd5, 32'd0, 32'd7, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 2'b01);
        tick();
        n_checks++; if (ex_zero !== 1'b0) begin n_fail++; $display("FAIL add_zero: actual %b required 0", ex_zero); end
        n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL add_latency: actual %b required 0", mem_valid); end
        idle();
        tick();
        n_checks++; if (mem_ALUResult !== 32'd12) begin n_fail++; $display("FAIL add_result: actual %0d required 12", mem_ALUResult); end
        n_checks++; if (mem_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: actual %b required 1", mem_valid); end
        n_checks++; if (mem_rd !== 5'd3 || mem_RegWrite !== 1'b1 || mem_ResultSrc !== 2'b01) begin
            n_fail++; $display("FAIL add_ctrl: actual rd=%0d rw=%b rs=%b required rd=3 rw=1 rs=01", mem_rd, mem_RegWrite, mem_ResultSrc); end
        tick();
        n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL add_bubble: actual %b required 0", mem_valid); end
    endtask

    task automatic test_logic();
        drive(1'b1, 3'b010, 1'b0, 32'h0000F0F0, 32'h0000FF00, '0, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0, 2'b00);
        tick();
        drive(1'b1, 3'b011, 1'b0, 32'h0000F0F0, 32'h0000FF00, '0, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0, 2'b00);
        tick();
        n_checks++; if (mem_ALUResult !== 32'h0000F000) begin n_fail++; $display("FAIL and_result: actual %h required 0000f000", mem_ALUResult); end
        n_checks++; if (mem_WriteData !== 32'h0000FF00) begin n_fail++; $display("FAIL and_wd: actual %h required 0000ff00", mem_WriteData); end
        idle();
        tick();
        n_checks++; if (mem_ALUResult !== 32'h0000FFF0) begin n_fail++; $display("FAIL or_result: actual %h required 0000fff0", mem_ALUResult); end
    endtask

    task automatic test_sub();
        drive(1'b1, 3'b001, 1'b0, 32'h10, 32'h10, '0, 5'd0, 5'd0, 5'd11, 1'b1, 1'b0, 2'b00);
        tick();
        n_checks++; if (ex_zero !== 1'b1) begin n_fail++; $display("FAIL sub_zero: actual %b required 1", ex_zero); end
        drive(1'b1, 3'b001, 1'b1, 32'd0, 32'd0, 32'd1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 2'b00);
        tick();
        n_checks++; if (ex_zero !== 1'b0) begin n_fail++; $display("FAIL sub_wrap_zero: actual %b required 0", ex_zero); end
        n_checks++; if (mem_ALUResult !== 32'd0 || mem_valid !== 1'b1) begin n_fail++; $display("FAIL sub_eq_result: actual %h v=%b required 0 v=1", mem_ALUResult, mem_valid); end
        idle();
        tick();
        n_checks++; if (mem_ALUResult !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL sub_wrap: actual %h required ffffffff", mem_ALUResult); end
    endtask

    task automatic test_slt();
        drive(1'b1, 3'b100, 1'b1, 32'hFFFFFFFF, '0, 32'd1, 5'd0, 5'd0, 5'd13, 1'b1, 1'b0, 2'b00);
        tick();
        drive(1'b1, 3'b100, 1'b1, 32'd1, '0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd13, 1'b1, 1'b0, 2'b00);
        tick();
        n_checks++; if (mem_ALUResult !== 32'd1) begin n_fail++; $display("FAIL slt_neg: actual %h required 1", mem_ALUResult); end
        n_checks++; if (ex_zero !== 1'b1) begin n_fail++; $display("FAIL slt_swap_zero: actual %b required 1", ex_zero); end
        drive(1'b1, 3'b101, 1'b1, 32'd3, '0, 32'd5, 5'd0, 5'd0, 5'd13, 1'b1, 1'b0, 2'b00);
        tick();
        n_checks++; if (mem_ALUResult !== 32'd0) begin n_fail++; $display("FAIL slt_swap: actual %h required 0", mem_ALUResult); end
        idle();
        tick();
        n_checks++; if (mem_ALUResult !== 32'd0 || mem_valid !== 1'b1) begin n_fail++; $display("FAIL code101: actual %h v=%b required 0 v=1", mem_ALUResult, mem_valid); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 3'b000, 1'b0, 32'd3, 32'd4, '0, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 2'b00);
        tick();
        drive(1'b1, 3'b000, 1'b0, 32'd0, 32'd0, '0, 5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 2'b00);
        tick();
        n_checks++; if (mem_ALUResult !== 32'd7) begin n_fail++; $display("FAIL dep_producer: actual %0d required 7", mem_ALUResult); end
        drive(1'b1, 3'b000, 1'b0, 32'd20, 32'd0, '0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 2'b00);
        tick();
        n_checks++; if (mem_ALUResult !== EXP_DEP) begin n_fail++; $display("FAIL dep_consumer: actual %0d required %0d", mem_ALUResult, EXP_DEP); end
        n_checks++; if (mem_WriteData !== EXP_WD) begin n_fail++; $display("FAIL dep_wd: actual %0d required %0d", mem_WriteData, EXP_WD); end
        drive(1'b1, 3'b000, 1'b1, 32'd0, 32'd0, 32'd0, 5'd5, 5'd0, 5'd7, 1'b1, 1'b0, 2'b00);
        wb_RegWrite = 1'b1; wb_rd = 5'd5; wb_Result = 32'd99;
        tick();
        n_checks++; if (mem_ALUResult !== 32'd20) begin n_fail++; $display("FAIL prio_producer: actual %0d required 20", mem_ALUResult); end
        drive(1'b1, 3'b000, 1'b1, 32'd0, 32'd0, 32'd0, 5'd5, 5'd0, 5'd8, 1'b1, 1'b0, 2'b00);
        tick();
        n_checks++; if (mem_ALUResult !== EXP_PRIO) begin n_fail++; $display("FAIL prio_mem_over_wb: actual %0d required %0d", mem_ALUResult, EXP_PRIO); end
        idle();
        tick();
        n_checks++; if (mem_ALUResult !== EXP_WB) begin n_fail++; $display("FAIL wb_forward: actual %0d required %0d", mem_ALUResult, EXP_WB); end
        wb_RegWrite = 1'b0; wb_rd = 5'd0; wb_Result = '0;
    endtask

    task automatic test_x0();
        drive(1'b1, 3'b000, 1'b0, 32'd9, 32'd0, '0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 2'b00);
        tick();
        drive(1'b1, 3'b000, 1'b1, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd14, 1'b1, 1'b0, 2'b00);
        wb_RegWrite = 1'b1; wb_rd = 5'd0; wb_Result = 32'd55;
        tick();
        n_checks++; if (mem_ALUResult !== 32'd9 || mem_rd !== 5'd0) begin n_fail++; $display("FAIL x0_producer: actual %0d rd=%0d required 9 rd=0", mem_ALUResult, mem_rd); end
        idle();
        tick();
        n_checks++; if (mem_ALUResult !== 32'd0) begin n_fail++; $display("FAIL x0_consumer: actual %0d required 0", mem_ALUResult); end
        wb_RegWrite = 1'b0; wb_Result = '0;
    endtask

    task automatic test_stall();
        drive(1'b1, 3'b000, 1'b1, 32'd1, 32'd0, 32'd2, 5'd0, 5'd0, 5'd16, 1'b1, 1'b0, 2'b00);
        tick();
        stall_e = 1'b1;
        drive(1'b1, 3'b000, 1'b1, 32'd100, 32'd0, 32'd0, 5'd0, 5'd0, 5'd17, 1'b1, 1'b0, 2'b00);
        tick();
        n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL stall_bubble1: actual %b required 0", mem_valid); end
        tick();
        n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL stall_bubble2: actual %b required 0", mem_valid); end
        stall_e = 1'b0;
        idle();
        tick();
        n_checks++; if (mem_valid !== 1'b1 || mem_ALUResult !== 32'd3 || mem_rd !== 5'd16) begin
            n_fail++; $display("FAIL stall_issue: actual v=%b r=%0d rd=%0d required v=1 r=3 rd=16", mem_valid, mem_ALUResult, mem_rd); end
        tick();
        n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL stall_once: actual %b required 0", mem_valid); end
    endtask

    task automatic test_flush();
        drive(1'b1, 3'b000, 1'b1, 32'h50, 32'd0, 32'd5, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 2'b10);
        tick();
        flush_e = 1'b1;
        drive(1'b1, 3'b000, 1'b1, 32'd7, 32'd0, 32'd0, 5'd0, 5'd0, 5'd18, 1'b1, 1'b0, 2'b00);
        tick();
        n_checks++; if (mem_valid !== 1'b1 || mem_ALUResult !== 32'h55 || mem_MemWrite !== 1'b1 || mem_ResultSrc !== 2'b10) begin
            n_fail++; $display("FAIL flush_retire: actual v=%b r=%h mw=%b rs=%b required v=1 r=55 mw=1 rs=10", mem_valid, mem_ALUResult, mem_MemWrite, mem_ResultSrc); end
        n_checks++; if (ex_zero !== 1'b0) begin n_fail++; $display("FAIL flush_zero: actual %b required 0", ex_zero); end
        flush_e = 1'b0;
        idle();
        tick();
        n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL flush_bubble: actual %b required 0", mem_valid); end
        drive(1'b1, 3'b000, 1'b1, 32'd10, 32'd0, 32'd0, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 2'b00);
        tick();
        stall_e = 1'b1; flush_e = 1'b1;
        tick();
        n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stall_edge: actual %b required 0", mem_valid); end
        stall_e = 1'b0; flush_e = 1'b0;
        idle();
        tick();
        n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stall_noissue: actual %b required 0", mem_valid); end
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b1, 3'b000, 1'b1, 32'd1, 32'd0, 32'd1, 5'd0, 5'd0, 5'd19, 1'b1, 1'b1, 2'b01);
        tick();
        stall_e = 1'b1;
        idle();
        tick();
        n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL rst_stall_bubble: actual %b required 0", mem_valid); end
        reset = 1'b1;
        tick();
        n_checks++; if (mem_ALUResult !== 32'd0 || mem_rd !== 5'd0 || mem_ResultSrc !== 2'b00 || ex_zero !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_clear: actual r=%h rd=%0d rs=%b z=%b required all 0", mem_ALUResult, mem_rd, mem_ResultSrc, ex_zero); end
        reset = 1'b0; stall_e = 1'b0;
        tick();
        n_checks++; if (mem_valid !== 1'b0 || mem_ALUResult !== 32'd0) begin n_fail++; $display("FAIL rst_mid_lost: actual v=%b r=%h required v=0 r=0", mem_valid, mem_ALUResult); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_logic();
        test_sub();
        test_slt();
        test_back_to_back();
        test_x0();
        test_stall();
        test_flush();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
